// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction-fetch stage and for later pipeline
// stages that slice the same instruction word.
//   - Bit positions of every instruction field.
//   - Fetch-stage state encoding.
//   - Default reset PC.
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JT_HI    = 25;
    localparam int JT_LO    = 0;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } if_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles the three buses around the fetch stage:
//   - instruction memory : imem_req/imem_addr out, imem_ack/imem_rdata in
//   - decode stage       : dec_valid + decoded fields + pc_plus4 out,
//                          dec_ready in
//   - redirect           : redirect_valid/redirect_pc in
// master : the fetch stage itself.
// slave  : the environment (memory, decoder, branch resolution).
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_W = 32
) ();

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    logic              dec_valid;
    logic              dec_ready;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       jtarget;
    logic [ADDR_W-1:0] pc_plus4;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dec_valid, opcode, funct, rs, rt, rd, shamt, imm, jtarget, pc_plus4,
        input  dec_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dec_valid, opcode, funct, rs, rt, rd, shamt, imm, jtarget, pc_plus4,
        output dec_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_field_split.sv
// ---------------------------------------------------------------------------
// if_field_split
// Purely combinational slicer from a 32-bit instruction word to its fields.
// Ports:
//   ir_i       instruction word
//   opcode_o   IR[31:26]      funct_o   IR[5:0]
//   rs_o       IR[25:21]      rt_o      IR[20:16]     rd_o  IR[15:11]
//   shamt_o    IR[10:6]       imm_o     IR[15:0]      jtarget_o IR[25:0]
// ---------------------------------------------------------------------------
module if_field_split
    import instr_fetch_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [5:0]  opcode_o,
    output logic [5:0]  funct_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [15:0] imm_o,
    output logic [25:0] jtarget_o
);

    assign opcode_o  = ir_i[OPC_HI:OPC_LO];
    assign funct_o   = ir_i[FUNCT_HI:FUNCT_LO];
    assign rs_o      = ir_i[RS_HI:RS_LO];
    assign rt_o      = ir_i[RT_HI:RT_LO];
    assign rd_o      = ir_i[RD_HI:RD_LO];
    assign shamt_o   = ir_i[SHAMT_HI:SHAMT_LO];
    assign imm_o     = ir_i[IMM_HI:IMM_LO];
    assign jtarget_o = ir_i[JT_HI:JT_LO];

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Holds the PC, fetches one instruction at a time from instruction memory
// with a req/ack handshake, latches it in IR and presents its decoded fields
// to the decode stage with a valid/ready handshake. Fetch and issue never
// overlap. Branch/jump resolution can redirect the PC at any time.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   instr_fetch_if.master (memory, decode and redirect buses)
// ---------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_if.master     bus
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
    logic              flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0] flush_pc_q, flush_pc_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] redirect_aligned;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_inc           = pc_q + ADDR_W'(4);
    assign redirect_aligned = bus.redirect_pc & ~ADDR_W'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            pc_plus4_q   <= '0;
            flush_pend_q <= 1'b0;
            flush_pc_q   <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            pc_plus4_q   <= pc_plus4_d;
            flush_pend_q <= flush_pend_d;
            flush_pc_q   <= flush_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        pc_plus4_d   = pc_plus4_q;
        flush_pend_d = flush_pend_q;
        flush_pc_d   = flush_pc_q;

        if (state_q == FETCH) begin
            if (bus.imem_ack) begin
                // A redirect coinciding with the ack, or one remembered from
                // earlier in this request, makes the returned word stale.
                if (bus.redirect_valid) begin
                    pc_d = redirect_aligned;
                end else if (flush_pend_q) begin
                    pc_d = flush_pc_q;
                end else begin
                    ir_d       = bus.imem_rdata;
                    pc_plus4_d = pc_inc;
                    pc_d       = pc_inc;
                    state_d    = ISSUE;
                end
                flush_pend_d = 1'b0;
            end else if (bus.redirect_valid) begin
                // The outstanding request cannot be withdrawn, so the target
                // is parked until its ack arrives; later redirects overwrite.
                flush_pc_d   = redirect_aligned;
                flush_pend_d = 1'b1;
            end
        end else begin
            if (bus.redirect_valid) begin
                pc_d    = redirect_aligned;
                state_d = FETCH;
            end else if (bus.dec_ready) begin
                state_d = FETCH;
            end
        end
    end

    // Request drops immediately when reset is asserted mid-request.
    assign bus.imem_req  = (state_q == FETCH) && !rst;
    assign bus.imem_addr = pc_q;
    assign bus.dec_valid = (state_q == ISSUE);
    assign bus.pc_plus4  = pc_plus4_q;

    if_field_split u_field_split (
        .ir_i      (ir_q),
        .opcode_o  (bus.opcode),
        .funct_o   (bus.funct),
        .rs_o      (bus.rs),
        .rt_o      (bus.rt),
        .rd_o      (bus.rd),
        .shamt_o   (bus.shamt),
        .imm_o     (bus.imm),
        .jtarget_o (bus.jtarget)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Drives instr_fetch through directed scenarios and a randomized phase and
// compares every output against a transaction-level reference model.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(32)) u_if  ();
    instr_fetch_if #(.ADDR_W(32)) u_if2 ();

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (u_if2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: "waiting for memory" vs "holding an instruction".
    bit          m_holding;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_pp4;
    bit          m_stale;
    logic [31:0] m_target;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_holding = 0;
        m_pc      = 32'h0;
        m_ir      = 32'h0;
        m_pp4     = 32'h0;
        m_stale   = 0;
        m_target  = 32'h0;
    endtask

    // Outputs expected from the model's current view.
    task automatic check_outputs();
        chk("req",   {31'b0, u_if.imem_req},  {31'b0, !m_holding});
        chk("valid", {31'b0, u_if.dec_valid}, {31'b0, m_holding});
        chk("addr",  u_if.imem_addr, m_pc);
        if (m_holding) begin
            chk("opcode",  32'(u_if.opcode),  m_ir / 32'h0400_0000);
            chk("funct",   32'(u_if.funct),   m_ir % 64);
            chk("rs",      32'(u_if.rs),      (m_ir / 32'h0020_0000) % 32);
            chk("rt",      32'(u_if.rt),      (m_ir / 32'h0001_0000) % 32);
            chk("rd",      32'(u_if.rd),      (m_ir / 32'h0000_0800) % 32);
            chk("shamt",   32'(u_if.shamt),   (m_ir / 64) % 32);
            chk("imm",     32'(u_if.imm),     m_ir % 65536);
            chk("jtarget", 32'(u_if.jtarget), m_ir % 32'h0400_0000);
            chk("pc_plus4", u_if.pc_plus4, m_pp4);
        end
    endtask

    // Apply one clock's worth of events to the model.
    task automatic model_advance(input bit ack, input logic [31:0] rdata,
                                 input bit ready, input bit rv, input logic [31:0] rpc);
        logic [31:0] tgt;
        tgt = rpc - (rpc % 4);
        if (!m_holding) begin
            if (ack) begin
                if (rv)            m_pc = tgt;
                else if (m_stale)  m_pc = m_target;
                else begin
                    m_ir      = rdata;
                    m_pp4     = m_pc + 4;
                    m_pc      = m_pc + 4;
                    m_holding = 1;
                end
                m_stale = 0;
            end else if (rv) begin
                m_target = tgt;
                m_stale  = 1;
            end
        end else if (rv) begin
            m_pc      = tgt;
            m_holding = 0;
        end else if (ready) begin
            m_holding = 0;
        end
    endtask

    // Called at a falling edge: drive inputs, check, advance one cycle.
    task automatic step(input bit ack, input logic [31:0] rdata,
                        input bit ready, input bit rv, input logic [31:0] rpc);
        u_if.imem_ack       = ack;
        u_if.imem_rdata     = rdata;
        u_if.dec_ready      = ready;
        u_if.redirect_valid = rv;
        u_if.redirect_pc    = rpc;
        check_outputs();
        model_advance(ack, rdata, ready, rv, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int wait_cnt;
        int lat;
        bit a, r, v;
        logic [31:0] d, p;

        u_if.imem_ack = 0;  u_if.imem_rdata = '0;  u_if.dec_ready = 0;
        u_if.redirect_valid = 0;  u_if.redirect_pc = '0;
        u_if2.imem_ack = 0; u_if2.imem_rdata = '0; u_if2.dec_ready = 0;
        u_if2.redirect_valid = 0; u_if2.redirect_pc = '0;
        model_reset();

        rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_req",      {31'b0, u_if.imem_req},  32'h0);
        chk("rst_valid",    {31'b0, u_if.dec_valid}, 32'h0);
        chk("rst_pc_plus4", u_if.pc_plus4, 32'h0);
        chk("rst_opcode",   32'(u_if.opcode), 32'h0);
        chk("rst_addr",     u_if.imem_addr, 32'h0);
        chk("rst_wrap_addr", u_if2.imem_addr, 32'hFFFF_FFFC);
        rst = 0;
        #1;

        // PC wrap-around on the second instance while the first idles.
        chk("wrap_req",   {31'b0, u_if2.imem_req}, 32'h1);
        chk("wrap_addr0", u_if2.imem_addr, 32'hFFFF_FFFC);
        u_if2.imem_ack   = 1;
        u_if2.imem_rdata = 32'h2000_0001;
        step(0, 32'h0, 0, 0, 32'h0);
        u_if2.imem_ack = 0;
        chk("wrap_valid",    {31'b0, u_if2.dec_valid}, 32'h1);
        chk("wrap_pc_plus4", u_if2.pc_plus4, 32'h0);
        u_if2.dec_ready = 1;
        step(0, 32'h0, 0, 0, 32'h0);
        u_if2.dec_ready = 0;
        chk("wrap_next_req",  {31'b0, u_if2.imem_req}, 32'h1);
        chk("wrap_next_addr", u_if2.imem_addr, 32'h0);

        // lw fetch, ack one cycle after the request is seen.
        chk("lw_addr", u_if.imem_addr, 32'h0);
        step(0, 32'h0, 0, 0, 32'h0);
        step(1, 32'h8C43_0004, 0, 0, 32'h0);
        chk("lw_valid",  {31'b0, u_if.dec_valid}, 32'h1);
        chk("lw_opcode", 32'(u_if.opcode), 32'h23);
        chk("lw_rs",     32'(u_if.rs), 32'h2);
        chk("lw_rt",     32'(u_if.rt), 32'h3);
        chk("lw_imm",    32'(u_if.imm), 32'h4);
        chk("lw_pc4",    u_if.pc_plus4, 32'h4);
        step(0, 32'h0, 1, 0, 32'h0);
        chk("lw_next_addr", u_if.imem_addr, 32'h4);

        // add held back by decode for five cycles.
        step(1, 32'h0022_1820, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_funct", 32'(u_if.funct), 32'h20);
            chk("stall_rd",    32'(u_if.rd), 32'h3);
            chk("stall_req",   {31'b0, u_if.imem_req}, 32'h0);
            step(0, 32'h0, 0, 0, 32'h0);
        end
        step(0, 32'h0, 1, 0, 32'h0);
        chk("stall_next_req",  {31'b0, u_if.imem_req}, 32'h1);
        chk("stall_next_addr", u_if.imem_addr, 32'h8);

        // Redirect three cycles before the ack: stale word must be dropped.
        step(0, 32'h0, 0, 1, 32'h40);
        step(0, 32'h0, 0, 0, 32'h0);
        step(0, 32'h0, 0, 0, 32'h0);
        chk("flush_held_addr", u_if.imem_addr, 32'h8);
        step(1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        chk("flush_valid", {31'b0, u_if.dec_valid}, 32'h0);
        chk("flush_addr",  u_if.imem_addr, 32'h40);

        // Redirect together with dec_ready while issuing.
        step(1, 32'h1234_5678, 0, 0, 32'h0);
        step(0, 32'h0, 1, 1, 32'h100);
        chk("issue_redir_addr", u_if.imem_addr, 32'h100);
        chk("issue_redir_req",  {31'b0, u_if.imem_req}, 32'h1);

        // Redirect coinciding with the ack (unaligned target).
        step(1, 32'hCAFE_F00D, 0, 1, 32'h203);
        chk("ackredir_valid", {31'b0, u_if.dec_valid}, 32'h0);
        chk("ackredir_addr",  u_if.imem_addr, 32'h200);

        // Reset pulsed mid-request.
        rst = 1;
        #1;
        chk("rstmid_req",   {31'b0, u_if.imem_req},  32'h0);
        chk("rstmid_valid", {31'b0, u_if.dec_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        #1;
        chk("rstmid_addr", u_if.imem_addr, 32'h0);
        chk("rstmid_req1", {31'b0, u_if.imem_req}, 32'h1);

        // Reset while an instruction is being presented.
        step(1, 32'h0800_0010, 0, 0, 32'h0);
        rst = 1;
        #1;
        chk("rstiss_valid", {31'b0, u_if.dec_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;
        #1;

        // Randomized traffic with variable memory latency.
        wait_cnt = 0;
        lat = $urandom_range(0, 3);
        for (int c = 0; c < 3000; c++) begin
            a = 0;
            if (!m_holding) begin
                if (wait_cnt >= lat) begin
                    a = 1;
                    wait_cnt = 0;
                    lat = $urandom_range(0, 3);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            d = $urandom;
            r = ($urandom % 3) != 0;
            v = ($urandom % 8) == 0;
            p = $urandom;
            step(a, d, r, v, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
